// File: rtl/iter_alu_if.sv
// Operand/result bundle for the multicycle execute unit.
// The control FSM drives the master side; iter_alu implements the slave side.
interface iter_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output start, alu_control, a, b,
    input  busy, done, result, zero, illegal
  );

  modport slave (
    input  start, alu_control, a, b,
    output busy, done, result, zero, illegal
  );
endinterface

// File: rtl/iter_alu.sv
// Multicycle execute unit: single-cycle logic/arith/compare ops,
// one-bit-per-cycle serial shifter for sll/srl/sra.
module iter_alu #(
  parameter int unsigned WIDTH = 32
) (
  input logic        clk,
  input logic        rst_n,
  iter_alu_if.slave  bus
);
  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpAnd  = 4'b0010;
  localparam logic [3:0] OpOr   = 4'b0011;
  localparam logic [3:0] OpSra  = 4'b0100;
  localparam logic [3:0] OpSlt  = 4'b0101;
  localparam logic [3:0] OpSrl  = 4'b0110;
  localparam logic [3:0] OpSll  = 4'b0111;
  localparam logic [3:0] OpSltu = 4'b1000;
  localparam logic [3:0] OpXor  = 4'b1001;

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] acc_shifted;
  logic [SW-1:0]    shamt;
  logic             is_shift;
  logic             legal;

  assign shamt = bus.b[SW-1:0];

  // Single-cycle datapath; a shift with n = 0 passes a through unchanged.
  always_comb begin
    alu_out  = '0;
    legal    = 1'b1;
    is_shift = 1'b0;
    case (bus.alu_control)
      OpAdd:  alu_out = bus.a + bus.b;
      OpSub:  alu_out = bus.a - bus.b;
      OpAnd:  alu_out = bus.a & bus.b;
      OpOr:   alu_out = bus.a | bus.b;
      OpXor:  alu_out = bus.a ^ bus.b;
      OpSlt:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OpSltu: alu_out = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OpSra, OpSrl, OpSll: begin
        is_shift = 1'b1;
        alu_out  = bus.a;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    case (op_q)
      OpSra:   acc_shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      OpSrl:   acc_shifted = {1'b0, acc_q[WIDTH-1:1]};
      default: acc_shifted = {acc_q[WIDTH-2:0], 1'b0};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (is_shift && (shamt != '0)) begin
            acc_d   = bus.a;
            cnt_d   = shamt;
            op_d    = bus.alu_control;
            state_d = StShift;
          end else begin
            result_d  = alu_out;
            zero_d    = (alu_out == '0);
            illegal_d = ~legal;
            done_d    = 1'b1;
          end
        end
      end
      StShift: begin
        acc_d = acc_shifted;
        cnt_d = cnt_q - SW'(1);
        // Last step: the freshly shifted value is the result.
        if (cnt_q == SW'(1)) begin
          result_d  = acc_shifted;
          zero_d    = (acc_shifted == '0);
          illegal_d = 1'b0;
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = (state_q == StShift);
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.zero    = zero_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_iter_alu;
  localparam int unsigned W  = 32;
  localparam int unsigned SW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  iter_alu_if #(.WIDTH(W)) bus ();

  iter_alu #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] prev_result;
  logic         prev_zero;
  logic         prev_illegal;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [3:0] code, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    int unsigned n;
    logic [W-1:0] r;
    n = int'(b[SW-1:0]);
    case (code)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = $signed(a) >>> n;
      4'd5:    r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd6:    r = a >> n;
      4'd7:    r = a << n;
      4'd8:    r = (a < b) ? 1 : 0;
      4'd9:    r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle with start low.
  task automatic run_op(input string tag, input logic [3:0] code, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int poke_at);
    logic [W-1:0] exp_r;
    int unsigned  n;
    bit           shift;
    int           lat;
    int           got;
    exp_r = model(code, a, b);
    n     = int'(b[SW-1:0]);
    shift = (code == 4'd4) || (code == 4'd6) || (code == 4'd7);
    lat   = (shift && n != 0) ? int'(n) + 1 : 1;
    got   = 0;
    bus.start       = 1'b1;
    bus.alu_control = code;
    bus.a           = a;
    bus.b           = b;
    @(posedge clk);
    for (int cyc = 1; cyc <= int'(W) + 4; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        got = cyc;
        break;
      end
      check({tag, " busy"}, 64'(bus.busy), 64'(lat > 1));
      check({tag, " hold"}, {bus.result, bus.zero, bus.illegal},
            {prev_result, prev_zero, prev_illegal});
      if (cyc == poke_at) begin
        bus.start       = 1'b1;
        bus.alu_control = 4'($urandom_range(0, 9));
        bus.a           = $urandom;
        bus.b           = $urandom;
      end
    end
    check({tag, " latency"}, 64'(got), 64'(lat));
    check({tag, " result"}, 64'(bus.result), 64'(exp_r));
    check({tag, " zero"}, 64'(bus.zero), 64'(exp_r == '0));
    check({tag, " illegal"}, 64'(bus.illegal), 64'(code > 4'd9));
    check({tag, " busy@done"}, 64'(bus.busy), 64'd0);
    prev_result  = exp_r;
    prev_zero    = (exp_r == '0);
    prev_illegal = (code > 4'd9);
  endtask

  task automatic idle_cycles(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check({tag, " no done"}, 64'(bus.done), 64'd0);
      check({tag, " no busy"}, 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    logic [3:0]   code;
    logic [W-1:0] ra, rb;

    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.alu_control = '0;
    bus.a           = '0;
    bus.b           = '0;
    prev_result     = '0;
    prev_zero       = 1'b1;
    prev_illegal    = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset result", 64'(bus.result), 64'd0);
    check("reset zero", 64'(bus.zero), 64'd1);
    check("reset illegal", 64'(bus.illegal), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add wrap", 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, -1);
    run_op("sub", 4'd1, 32'h0000_0005, 32'h0000_0007, -1);
    run_op("slt", 4'd5, 32'hFFFF_FFFE, 32'h0000_0001, -1);
    run_op("sltu", 4'd8, 32'hFFFF_FFFE, 32'h0000_0001, -1);
    run_op("sra4", 4'd4, 32'h8000_0000, 32'h0000_0024, -1);
    run_op("srl4", 4'd6, 32'h8000_0000, 32'h0000_0024, -1);
    run_op("sll31 poke", 4'd7, 32'h0000_0001, 32'h0000_001F, 10);
    idle_cycles("after sll31", 5);
    run_op("xor", 4'd9, 32'h0000_FF00, 32'h0000_0FF0, -1);
    run_op("and b2b", 4'd2, 32'h0000_1234, 32'h0000_0F0F, -1);
    run_op("sll n0", 4'd7, 32'hDEAD_BEEF, 32'h0000_0020, -1);
    run_op("illegal", 4'd12, 32'h1234_5678, 32'h0000_0001, -1);

    // Abort a shift with reset after its third busy cycle.
    bus.start       = 1'b1;
    bus.alu_control = 4'd7;
    bus.a           = 32'h0000_00A5;
    bus.b           = 32'h0000_0008;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre-abort busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    check("abort illegal", 64'(bus.illegal), 64'd0);
    check("abort result", 64'(bus.result), 64'd0);
    check("abort zero", 64'(bus.zero), 64'd1);
    @(negedge clk);
    rst_n        = 1'b1;
    prev_result  = '0;
    prev_zero    = 1'b1;
    prev_illegal = 1'b0;
    idle_cycles("post-abort", 12);
    run_op("post-abort or", 4'd3, 32'h0F00_0000, 32'h0000_00F0, -1);

    for (int i = 0; i < 250; i++) begin
      code = 4'($urandom_range(0, 15));
      ra   = $urandom;
      rb   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (($urandom & 3) == 0) ra = '0;
      run_op("rand", code, ra, rb, ($urandom_range(0, 3) == 0) ? 2 : -1);
      if (($urandom & 3) == 0) idle_cycles("rand gap", 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/iter_alu.md
# iter_alu

Multicycle execute unit that consumes the 4-bit `alu_control` code produced by the ALU decoder and computes the datapath result. Logic, arithmetic and compare ops finish in one cycle. Shifts run on a one-bit-per-cycle serial shifter to save area. It sits between the register/operand latches and the ALUOut register of the multicycle core, and the main control FSM sequences it through a start/done handshake.

## Interface
- `WIDTH`, 32, operand/result width; power of two, ≥ 8; shift amount width `SW = log2(WIDTH)`
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only when `busy` = 0
- `alu_control`  in  4  operation code, sampled with `start`
- `a`  in  WIDTH  operand A, sampled with `start`
- `b`  in  WIDTH  operand B, sampled with `start`; shift amount = `b[SW-1:0]`
- `busy`  out  1  serial shift in progress; `start` ignored while high
- `done`  out  1  one-cycle completion pulse; `result`, `zero` and `illegal` are valid from this cycle on
- `result`  out  WIDTH  registered result, held until the next completion
- `zero`  out  1  registered `result == 0`
- `illegal`  out  1  registered flag, set when the last op had an unsupported code

## Operation
- Codes:
  - 0000 add
  - 0001 sub
  - 0010 and
  - 0011 or
  - 0100 sra
  - 0101 slt (signed)
  - 0110 srl
  - 0111 sll
  - 1000 sltu
  - 1001 xor
  - 1010–1111 illegal
- Add and sub wrap modulo 2^WIDTH. No carry or overflow outputs.
- slt and sltu produce 1 or 0, zero-extended to WIDTH.
- Illegal code: `result` = 0, `zero` = 1, `illegal` = 1, single-cycle latency.
- Legal completion clears `illegal`.
- FSM states: IDLE, SHIFT.
- IDLE, `start` = 1 with a non-shift code or shift amount n = 0:
  - compute the result combinationally from the sampled inputs
  - register `result`, `zero` and `illegal`
  - pulse `done` next cycle
  - stay in IDLE
- IDLE, `start` = 1 with a shift code and n > 0:
  - latch `a` into the accumulator, n into the counter, and the op
  - go to SHIFT
- SHIFT, each cycle:
  - shift the accumulator one bit: sll shifts in 0 at the LSB; srl shifts in 0 at the MSB; sra replicates the MSB
  - decrement the counter
- SHIFT, when the counter reaches 0:
  - load `result` and `zero`, clear `illegal`
  - pulse `done`
  - return to IDLE
- `start` while `busy` = 1 is ignored: operands are not re-sampled and no extra `done` is produced.
- The shift amount uses only `b[SW-1:0]`; upper bits of `b` are ignored.
- Reset values:
  - state IDLE
  - `busy` 0, `done` 0
  - `result` 0, `zero` 1, `illegal` 0
  - counter and accumulator 0

## Timing
- `start` sampled at edge T (end of cycle T).
- Non-shift, illegal, or n = 0: `done` = 1 in cycle T+1. `busy` is never asserted.
- Shift with n > 0:
  - `busy` = 1 in cycles T+1 … T+n
  - `done` = 1 and `busy` = 0 in cycle T+1+n
  - total latency 1+n cycles; worst case WIDTH cycles at n = WIDTH−1
- Back-to-back: `start` may be asserted in the cycle `done` is high; that op completes at the normal latency counted from then.
- `result`, `zero` and `illegal` change only at the edge that raises `done`.
- Async reset mid-SHIFT: outputs return to reset values immediately. The aborted op never produces `done`. The first `start` after release behaves normally.

## Test plan
- add 0xFFFFFFFF + 0x00000001, start at T → `done` at T+1, `result` 0x00000000, `zero` 1, `busy` never high.
- sub 0x00000005 − 0x00000007 → `result` 0xFFFFFFFE. slt with a = −2, b = 1 → `result` 1. sltu with the same operands → `result` 0.
- sra a = 0x80000000, b = 0x00000024 (n = 4), start at T → `busy` high T+1..T+4, `done` at T+5, `result` 0xF8000000. srl with the same operands → 0x08000000.
- sll a = 1, n = 31 → `done` exactly 32 cycles after the start edge, `result` 0x80000000. A `start` pulsed mid-shift is ignored: no extra `done`, operands unchanged.
- Back-to-back: xor 0xFF00 ^ 0x0FF0 → `result` 0xF0F0; a second `start` (and 0x1234 & 0x0F0F) asserted in the `done` cycle → `done` on the next cycle, `result` 0x0204.
- Code 1100 → `result` 0, `illegal` 1, `done` at T+1. Then an sll with n = 8 reset via `rst_n` low at cycle 3 of the shift → `busy`, `done`, `illegal` at 0, `result` 0, `zero` 1 immediately; no `done` after release.
